// File: rtl/inst_mem_arbiter_pkg.sv
// Shared encodings for the instruction-memory arbiter: FSM states and port IDs.
package inst_mem_arbiter_pkg;

  typedef enum logic {
    ARB_ST_ARB   = 1'b0,
    ARB_ST_LOCK1 = 1'b1
  } arb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating wait counter for the loader port; at_max forces m1 ahead of the fetch port.
module arb_age_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  assign at_max = (count == CW'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Single-port instruction memory arbiter: core fetch (m0) vs loader (m1) with m1 lock.
// Build option ARB_RR_EN: round-robin in ARB state instead of fixed priority + aging.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_i,
  input  logic [AW-1:0] m0_addr_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_lock_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output arb_state_e    dbg_state
);

  // Handshake: a master holds req (and its addr/data) until it sees gnt in the same
  // cycle; the transfer happens on that edge and a new req may follow immediately.

  arb_state_e state;
  logic       m0_win;
  logic       m1_win;
  logic       rd_pend;
  logic       rd_owner;

  assign dbg_state = state;

`ifdef ARB_RR_EN
  logic last_gnt;

  always_comb begin
    m0_win = 1'b0;
    m1_win = 1'b0;
    if (state == ARB_ST_LOCK1) begin
      m1_win = m1_req_i;
    end else if (m0_req_i && m1_req_i) begin
      if (last_gnt == ARB_M1) m0_win = 1'b1;
      else                    m1_win = 1'b1;
    end else begin
      m0_win = m0_req_i;
      m1_win = m1_req_i;
    end
  end

  // Pointer resets to m1 so the fetch port wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= ARB_M1;
    end else if (m0_gnt_o) begin
      last_gnt <= ARB_M0;
    end else if (m1_gnt_o) begin
      last_gnt <= ARB_M1;
    end
  end
`else
  logic at_max;
  logic age_inc;
  logic age_clr;

  assign age_inc = (state == ARB_ST_ARB) && m1_req_i && !m1_gnt_o;
  assign age_clr = m1_gnt_o || !m1_req_i;

  arb_age_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk    (clk),
    .rst    (rst),
    .inc    (age_inc),
    .clr    (age_clr),
    .at_max (at_max)
  );

  always_comb begin
    m0_win = 1'b0;
    m1_win = 1'b0;
    if (state == ARB_ST_LOCK1) begin
      m1_win = m1_req_i;
    end else if (at_max && m1_req_i) begin
      m1_win = 1'b1;
    end else if (m0_req_i) begin
      m0_win = 1'b1;
    end else begin
      m1_win = m1_req_i;
    end
  end
`endif

  // Grants are gated by reset so the memory sees no strobe while held in reset.
  assign m0_gnt_o    = m0_win & rst;
  assign m1_gnt_o    = m1_win & rst;
  assign mem_req_o   = m0_gnt_o | m1_gnt_o;
  assign mem_we_o    = m1_gnt_o & m1_we_i;
  assign mem_addr_o  = m0_gnt_o ? m0_addr_i : (m1_gnt_o ? m1_addr_i : '0);
  assign mem_wdata_o = m1_gnt_o ? m1_wdata_i : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_ST_ARB;
      rd_pend  <= 1'b0;
      rd_owner <= ARB_M0;
    end else begin
      rd_pend  <= m0_gnt_o | (m1_gnt_o & ~m1_we_i);
      rd_owner <= m1_gnt_o ? ARB_M1 : ARB_M0;
      case (state)
        ARB_ST_ARB:   if (m1_gnt_o && m1_lock_i) state <= ARB_ST_LOCK1;
        ARB_ST_LOCK1: if (!m1_lock_i)            state <= ARB_ST_ARB;
      endcase
    end
  end

  assign m0_rvalid_o = rd_pend && (rd_owner == ARB_M0);
  assign m1_rvalid_o = rd_pend && (rd_owner == ARB_M1);
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench for inst_mem_arbiter: memory model, read-data scoreboard, grant checks.
module tb_inst_mem_arbiter;
  import inst_mem_arbiter_pkg::*;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req_i;
  logic [AW-1:0] m0_addr_i;
  logic          m0_gnt_o;
  logic          m0_rvalid_o;
  logic [DW-1:0] m0_rdata_o;
  logic          m1_req_i;
  logic          m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_wdata_i;
  logic          m1_lock_i;
  logic          m1_gnt_o;
  logic          m1_rvalid_o;
  logic [DW-1:0] m1_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  arb_state_e    dbg_state;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m0_exp_q[$];
  logic [DW-1:0] m1_exp_q[$];
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] mem_arr [0:63];

  inst_mem_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req_i    (m0_req_i),
    .m0_addr_i   (m0_addr_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_req_i    (m1_req_i),
    .m1_we_i     (m1_we_i),
    .m1_addr_i   (m1_addr_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_lock_i   (m1_lock_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] init_pat(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // ---------------- memory model (1-cycle read latency) ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = init_pat(i);
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      if (mem_req_o) begin
        if (mem_we_o) mem_arr[mem_addr_o[7:2]] = mem_wdata_o;
        else          mem_rdata_i <= mem_arr[mem_addr_o[7:2]];
      end
    end
  end

  // ---------------- checkers ----------------
  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_bit ({tag, "_m0_gnt"},    m0_gnt_o,    1'b0);
    chk_bit ({tag, "_m1_gnt"},    m1_gnt_o,    1'b0);
    chk_bit ({tag, "_mem_req"},   mem_req_o,   1'b0);
    chk_bit ({tag, "_mem_we"},    mem_we_o,    1'b0);
    chk_word({tag, "_mem_addr"},  mem_addr_o,  '0);
    chk_word({tag, "_mem_wdata"}, mem_wdata_o, '0);
    chk_bit ({tag, "_m0_rvalid"}, m0_rvalid_o, 1'b0);
    chk_bit ({tag, "_m1_rvalid"}, m1_rvalid_o, 1'b0);
    chk_word({tag, "_m0_rdata"},  m0_rdata_o,  '0);
    chk_word({tag, "_m1_rdata"},  m1_rdata_o,  '0);
    chk_bit ({tag, "_state"},     dbg_state,   ARB_ST_ARB);
  endtask

  // One bus cycle: score read data at negedge, record grants, push expectations.
  task automatic cycle(output logic g0, output logic g1);
    logic [DW-1:0] e;
    @(negedge clk);
    chk_bit("m0_rvalid", m0_rvalid_o, m0_exp_q.size() != 0);
    if (m0_exp_q.size() != 0) begin
      e = m0_exp_q.pop_front();
      chk_word("m0_rdata", m0_rdata_o, e);
    end else begin
      chk_word("m0_rdata_idle", m0_rdata_o, '0);
    end
    chk_bit("m1_rvalid", m1_rvalid_o, m1_exp_q.size() != 0);
    if (m1_exp_q.size() != 0) begin
      e = m1_exp_q.pop_front();
      chk_word("m1_rdata", m1_rdata_o, e);
    end else begin
      chk_word("m1_rdata_idle", m1_rdata_o, '0);
    end
    g0 = m0_gnt_o;
    g1 = m1_gnt_o;
    chk_bit("one_gnt", g0 & g1, 1'b0);
    chk_bit("mem_req", mem_req_o, g0 | g1);
    if (g0) begin
      chk_word("mem_addr_m0", mem_addr_o, m0_addr_i);
      chk_bit ("mem_we_m0",   mem_we_o,   1'b0);
      m0_exp_q.push_back(ref_mem[m0_addr_i[7:2]]);
    end
    if (g1) begin
      chk_word("mem_addr_m1", mem_addr_o, m1_addr_i);
      chk_bit ("mem_we_m1",   mem_we_o,   m1_we_i);
      if (m1_we_i) begin
        chk_word("mem_wdata_m1", mem_wdata_o, m1_wdata_i);
        ref_mem[m1_addr_i[7:2]] = m1_wdata_i;
      end else begin
        m1_exp_q.push_back(ref_mem[m1_addr_i[7:2]]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input string tag, input logic g0, input logic g1,
                            input logic e0, input logic e1);
    chk_bit({tag, "_m0_gnt"}, g0, e0);
    chk_bit({tag, "_m1_gnt"}, g1, e1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic g0, g1;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_pat(i);

    // Reset with both requests raised: every output must stay 0.
    rst        = 1'b0;
    m0_req_i   = 1'b1;
    m0_addr_i  = 32'h4;
    m1_req_i   = 1'b1;
    m1_we_i    = 1'b1;
    m1_addr_i  = 32'h8;
    m1_wdata_i = 32'h1234_5678;
    m1_lock_i  = 1'b1;
    #12;
    chk_all_zero("reset");
    m0_req_i  = 1'b0;
    m1_req_i  = 1'b0;
    m1_we_i   = 1'b0;
    m1_lock_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // m0 back-to-back fetches 0x0, 0x4, 0x8.
    m0_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m0_addr_i = 32'(i * 4);
      cycle(g0, g1);
      expect_gnt("t1", g0, g1, 1'b1, 1'b0);
    end
    m0_req_i = 1'b0;
    cycle(g0, g1);
    expect_gnt("t1_idle", g0, g1, 1'b0, 1'b0);

`ifndef ARB_RR_EN
    // Both held: m0 wins MAX_WAIT cycles, then aging forces one m1 grant.
    m0_req_i  = 1'b1;
    m1_req_i  = 1'b1;
    m1_we_i   = 1'b0;
    m1_addr_i = 32'h20;
    for (int i = 0; i < MAX_WAIT; i++) begin
      m0_addr_i = 32'h40 + 32'(i * 4);
      cycle(g0, g1);
      expect_gnt("t2_m0_first", g0, g1, 1'b1, 1'b0);
    end
    m0_addr_i = 32'h60;
    cycle(g0, g1);
    expect_gnt("t2_aged", g0, g1, 1'b0, 1'b1);
    m1_req_i = 1'b0;
    cycle(g0, g1);
    expect_gnt("t2_resume", g0, g1, 1'b1, 1'b0);
    m0_req_i = 1'b0;
    cycle(g0, g1);
    chk_bit("t2_state", dbg_state, ARB_ST_ARB);
`endif

    // Locked loader burst: m0 starves until lock drops; writes give no rvalid.
    m1_req_i   = 1'b1;
    m1_we_i    = 1'b1;
    m1_lock_i  = 1'b1;
    m1_addr_i  = 32'h10;
    m1_wdata_i = 32'hDEAD_BEEF;
    cycle(g0, g1);
    expect_gnt("t3_w0", g0, g1, 1'b0, 1'b1);
    chk_bit("t3_locked", dbg_state, ARB_ST_LOCK1);
    m0_req_i   = 1'b1;
    m0_addr_i  = 32'h0;
    m1_addr_i  = 32'h14;
    m1_wdata_i = 32'h1111_2222;
    cycle(g0, g1);
    expect_gnt("t3_w1", g0, g1, 1'b0, 1'b1);
    m1_req_i = 1'b0;
    cycle(g0, g1);
    expect_gnt("t3_lock_idle", g0, g1, 1'b0, 1'b0);
    chk_bit("t3_still_locked", dbg_state, ARB_ST_LOCK1);
    m1_req_i   = 1'b1;
    m1_addr_i  = 32'h18;
    m1_wdata_i = 32'h3333_4444;
    cycle(g0, g1);
    expect_gnt("t3_w2", g0, g1, 1'b0, 1'b1);
    m1_addr_i  = 32'h1C;
    m1_wdata_i = 32'h5555_6666;
    m1_lock_i  = 1'b0;
    cycle(g0, g1);
    expect_gnt("t3_w3_unlock", g0, g1, 1'b0, 1'b1);
    chk_bit("t3_unlocked", dbg_state, ARB_ST_ARB);
    m1_req_i = 1'b0;
    m1_we_i  = 1'b0;
    cycle(g0, g1);
    expect_gnt("t3_m0_back", g0, g1, 1'b1, 1'b0);
    m0_req_i  = 1'b0;
    m1_req_i  = 1'b1;
    m1_addr_i = 32'h1C;
    cycle(g0, g1);
    expect_gnt("t3_readback", g0, g1, 1'b0, 1'b1);
    m1_req_i = 1'b0;
    cycle(g0, g1);

    // Reset lands while an m1 read is in flight: its rvalid must never appear.
    m1_req_i  = 1'b1;
    m1_we_i   = 1'b0;
    m1_addr_i = 32'h24;
    cycle(g0, g1);
    expect_gnt("t4_grant", g0, g1, 1'b0, 1'b1);
    rst = 1'b0;
    m1_exp_q.delete();
    m0_req_i = 1'b1;
    #1;
    chk_all_zero("t4_in_reset");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("t4_held");
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) begin
      cycle(g0, g1);
      expect_gnt("t4_after", g0, g1, 1'b0, 1'b0);
    end

`ifdef ARB_RR_EN
    // Round-robin from a fresh reset: alternating grants, m0 first.
    m0_req_i  = 1'b1;
    m1_req_i  = 1'b1;
    m1_we_i   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m0_addr_i = 32'h40 + 32'(i * 4);
      m1_addr_i = 32'h80 + 32'(i * 4);
      cycle(g0, g1);
      expect_gnt("t5_rr", g0, g1, (i % 2) == 0, (i % 2) == 1);
    end
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    cycle(g0, g1);
`endif

    // m0 read then m1 read on consecutive cycles.
    m0_req_i  = 1'b1;
    m0_addr_i = 32'h8;
    cycle(g0, g1);
    expect_gnt("t6_m0", g0, g1, 1'b1, 1'b0);
    m0_req_i  = 1'b0;
    m1_req_i  = 1'b1;
    m1_we_i   = 1'b0;
    m1_addr_i = 32'h10;
    cycle(g0, g1);
    expect_gnt("t6_m1", g0, g1, 1'b0, 1'b1);
    m1_req_i = 1'b0;
    cycle(g0, g1);
    cycle(g0, g1);
    chk_bit("sb_m0_empty", m0_exp_q.size() == 0, 1'b1);
    chk_bit("sb_m1_empty", m1_exp_q.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
